// File: rtl/regfile_master.sv
// regfile_master
//   Command-driven master for a register file with one write port (WEN/RW/busW)
//   and two combinational read ports (RX->busX, RY->busY).
//   A write command is presented to the register file for one cycle. A read
//   command drives RX/RY, captures busX/busY on the next cycle and holds the
//   response until it is consumed.
//
// Ports
//   Clk         rising-edge clock
//   Rst_n       synchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   block can accept a command (idle)
//   cmd_op      1 = write, 0 = read
//   cmd_addr_a  write address / X read address
//   cmd_addr_b  Y read address (ignored on writes)
//   cmd_data    write data (ignored on reads)
//   WEN,RW,busW register-file write port
//   RX,RY       register-file read addresses
//   busX,busY   register-file read data (combinational)
//   rsp_valid   response present
//   rsp_ready   response consumed
//   rsp_x,rsp_y response data
//
// Configuration
//   REGFILE_MASTER_WRITE_ACK_EN : when defined, each write also produces a
//   response (rsp_x = written data, rsp_y = 0).
module regfile_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              WEN,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] busW,
  output logic [ADDR_W-1:0] RX,
  output logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] busX,
  input  logic [DATA_W-1:0] busY,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_x,
  output logic [DATA_W-1:0] rsp_y
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t state;
  state_t state_nxt;

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = cmd_op ? WRITE : READ;
`ifdef REGFILE_MASTER_WRITE_ACK_EN
      WRITE: state_nxt = RESP;
`else
      WRITE: state_nxt = IDLE;
`endif
      READ:  state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cmd_ready = (state == IDLE);
  end

  // Registered port drive and response capture. Command fields are sampled
  // only in IDLE with cmd_valid high, i.e. on the acceptance edge.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      WEN       <= 1'b0;
      RW        <= '0;
      busW      <= '0;
      RX        <= '0;
      RY        <= '0;
      rsp_valid <= 1'b0;
      rsp_x     <= '0;
      rsp_y     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_op) begin
              RW   <= cmd_addr_a;
              busW <= cmd_data;
              WEN  <= 1'b1;
            end else begin
              RX <= cmd_addr_a;
              RY <= cmd_addr_b;
            end
          end
        end
        WRITE: begin
          WEN <= 1'b0;
`ifdef REGFILE_MASTER_WRITE_ACK_EN
          rsp_x     <= busW;
          rsp_y     <= '0;
          rsp_valid <= 1'b1;
`endif
        end
        READ: begin
          rsp_x     <= busX;
          rsp_y     <= busY;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// Self-checking bench for regfile_master: a behavioural register file sits on
// the RW/RX/RY ports, and an independent array holds the expected contents.
module tb_regfile_master;

  logic       clk = 1'b0;
  logic       Rst_n;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [2:0] cmd_addr_a, cmd_addr_b;
  logic [7:0] cmd_data;
  logic       WEN;
  logic [2:0] RW, RX, RY;
  logic [7:0] busW, busX, busY;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_x, rsp_y;

  int errors = 0;
  int checks = 0;

  bit [7:0] model [8];

`ifdef REGFILE_MASTER_WRITE_ACK_EN
  localparam int WR_PERIOD = 3;
`else
  localparam int WR_PERIOD = 2;
`endif

  regfile_master #(.DATA_W(8), .ADDR_W(3)) dut (
    .Clk(clk), .Rst_n(Rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_data(cmd_data),
    .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
    .busX(busX), .busY(busY),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y)
  );

  always #5 clk = ~clk;

  // Register file: synchronous write, combinational reads
  logic [7:0] rf [8] = '{default: 8'h00};
  always @(posedge clk) if (WEN) rf[RW] <= busW;
  assign busX = rf[RX];
  assign busY = rf[RY];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a command and return #1 after the acceptance edge, with the
  // command fields scrambled so late sampling would be noticed.
  task automatic issue(input bit op, input bit [2:0] a, input bit [2:0] b, input bit [7:0] d);
    bit ok = 0;
    cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_data = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_op     = 1'($urandom);
    cmd_addr_a = 3'($urandom);
    cmd_addr_b = 3'($urandom);
    cmd_data   = 8'($urandom);
  endtask

  task automatic do_write(input bit [2:0] a, input bit [7:0] d);
    issue(1'b1, a, 3'($urandom), d);
    chk("wr_wen_hi", WEN, 1);
    chk("wr_rw", RW, a);
    chk("wr_busw", busW, d);
    chk("wr_busy", cmd_ready, 0);
    model[a] = d;
    @(posedge clk); #1;
    chk("wr_wen_lo", WEN, 0);
`ifdef REGFILE_MASTER_WRITE_ACK_EN
    chk("wack_valid", rsp_valid, 1);
    chk("wack_x", rsp_x, d);
    chk("wack_y", rsp_y, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("wack_drop", rsp_valid, 0);
`else
    chk("wr_no_rsp", rsp_valid, 0);
`endif
    chk("wr_ready_again", cmd_ready, 1);
  endtask

  // During the hold period a write command is offered; it must be ignored.
  task automatic do_read(input bit [2:0] a, input bit [2:0] b,
                         input bit [7:0] ex, input bit [7:0] ey, input int hold);
    issue(1'b0, a, b, 8'($urandom));
    chk("rd_rx", RX, a);
    chk("rd_ry", RY, b);
    chk("rd_lat_early", rsp_valid, 0);
    @(posedge clk); #1;
    chk("rd_valid", rsp_valid, 1);
    chk("rd_x", rsp_x, ex);
    chk("rd_y", rsp_y, ey);
    if (hold > 0) begin
      cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr_a = a; cmd_data = ~ex;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_x", rsp_x, ex);
      chk("bp_y", rsp_y, ey);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_wen", WEN, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rd_drop", rsp_valid, 0);
    chk("rd_ready_again", cmd_ready, 1);
  endtask

  typedef struct {
    bit       op;
    bit [2:0] a;
    bit [2:0] b;
    bit [7:0] d;
    bit [7:0] ex;
    bit [7:0] ey;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit wen_q [$];
    int rises, last_rise, run, max_run;

    // op, a, b, data, expected x, expected y
    vecs[0] = '{1, 3, 0, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{0, 3, 0, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{1, 0, 0, 8'h5A, 8'h00, 8'h00};
    vecs[3] = '{0, 3, 0, 8'h00, 8'hA5, 8'h5A};
    vecs[4] = '{0, 0, 3, 8'h00, 8'h5A, 8'hA5};
    vecs[5] = '{1, 7, 0, 8'hFF, 8'h00, 8'h00};
    vecs[6] = '{0, 7, 7, 8'h00, 8'hFF, 8'hFF};
    vecs[7] = '{1, 7, 0, 8'h00, 8'h00, 8'h00};
    vecs[8] = '{0, 7, 3, 8'h00, 8'h00, 8'hA5};
    vecs[9] = '{0, 1, 2, 8'h00, 8'h00, 8'h00};

    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    Rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; rsp_ready = 1'b0;
    cmd_addr_a = '0; cmd_addr_b = '0; cmd_data = '0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", WEN, 0);
    chk("rst_rw", RW, 0);
    chk("rst_busw", busW, 0);
    chk("rst_rx", RX, 0);
    chk("rst_ry", RY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_x", rsp_x, 0);
    chk("rst_rsp_y", rsp_y, 0);
    Rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_cmd_ready", cmd_ready, 1);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].op) do_write(vecs[i].a, vecs[i].d);
      else            do_read(vecs[i].a, vecs[i].b, vecs[i].ex, vecs[i].ey, 0);
    end

    // Backpressure: response held 5 cycles
    do_read(3, 0, model[3], model[0], 5);

    // Back-to-back writes with cmd_valid held high
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit ok = 0;
      cmd_addr_a = 3'(i); cmd_data = 8'h10 + 8'(i);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        wen_q.push_back(WEN);
        if (cmd_ready) begin ok = 1; break; end
      end
      if (!ok) chk("b2b_accept_timeout", 0, 1);
      @(posedge clk); #1;
      model[i] = 8'h10 + 8'(i);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    wen_q.push_back(WEN);
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    rises = 0; last_rise = -1; run = 0; max_run = 0;
    for (int i = 0; i < wen_q.size(); i++) begin
      if (wen_q[i]) begin
        run++;
        if (run > max_run) max_run = run;
        if (run == 1) begin
          if (last_rise >= 0) chk("b2b_period", i - last_rise, WR_PERIOD);
          last_rise = i;
          rises++;
        end
      end else run = 0;
    end
    chk("b2b_pulses", rises, 8);
    chk("b2b_width", max_run, 1);
    for (int i = 0; i < 8; i++)
      do_read(3'(i), 3'(7 - i), 8'h10 + 8'(i), 8'h17 - 8'(i), 0);

    // Reset during READ
    issue(1'b0, 2, 5, 8'h00);
    Rst_n = 1'b0;
    @(posedge clk); #1;
    Rst_n = 1'b1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_rx", RX, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    do_read(2, 5, model[2], model[5], 1);

    // Randomized traffic against the expected-contents array
    for (int n = 0; n < 60; n++) begin
      bit [2:0] a = 3'($urandom);
      bit [2:0] b = 3'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom));
      else do_read(a, b, model[a], model[b], $urandom_range(0, 3));
    end

`ifdef REGFILE_MASTER_WRITE_ACK_EN
    do_write(5, 8'h3C);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
